// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and divider helper for the UART receiver
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Clock cycles per oversample tick; truncation is deliberate
  function automatic int calc_tick_div(input int clock_rate, input int baud_rate,
                                       input int oversample);
    return clock_rate / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// rtl/uart_rx_tick_gen.sv - oversample tick divider with synchronous phase clear
module uart_rx_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running 0..TICK_DIV-1 counter, held at zero while cleared so phase tracks start detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing error detection
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TICK_DIV = calc_tick_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [SW-1:0] SAMPLE_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(UART_DATA_BITS - 1);

  // Achieved line rate must be within 2% of the requested baud rate
  localparam longint ACHIEVED = longint'(TICK_DIV) * longint'(OVERSAMPLE) * longint'(BAUD_RATE);
  localparam longint RATE_DIFF = (longint'(CLOCK_RATE) > ACHIEVED) ?
                                 (longint'(CLOCK_RATE) - ACHIEVED) :
                                 (ACHIEVED - longint'(CLOCK_RATE));

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("uart_rx: clock too slow for BAUD_RATE * OVERSAMPLE");
  end else if ((RATE_DIFF * 50) > ACHIEVED) begin : g_bad_rate
    $error("uart_rx: bit-rate error exceeds 2 percent");
  end

  logic            rx_meta;
  logic            rx_s;
  rx_state_t       state;
  rx_state_t       state_next;
  logic            tick;
  logic            tick_clear;
  logic [SW-1:0]   sample_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [7:0]      shift_reg;
  logic            sample_clr;
  logic            sample_inc;
  logic            bit_clr;
  logic            bit_inc;
  logic            shift_en;
  logic            load_data;
  logic            set_ferr;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  assign tick_clear = !rx_en || (state == IDLE) || (state == WAIT_HIGH);

  uart_rx_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(tick_clear),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes; sampling happens only on the tick that lands mid-bit
  always_comb begin
    state_next = state;
    sample_clr = 1'b0;
    sample_inc = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    shift_en   = 1'b0;
    load_data  = 1'b0;
    set_ferr   = 1'b0;
    if (!rx_en) begin
      state_next = IDLE;
      sample_clr = 1'b1;
      bit_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          sample_clr = 1'b1;
          bit_clr    = 1'b1;
          if (!rx_s) state_next = START;
        end
        START: begin
          if (tick) begin
            if (sample_cnt == SAMPLE_MID) begin
              sample_clr = 1'b1;
              bit_clr    = 1'b1;
              state_next = rx_s ? IDLE : DATA;
            end else begin
              sample_inc = 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sample_cnt == SAMPLE_LAST) begin
              sample_clr = 1'b1;
              shift_en   = 1'b1;
              bit_inc    = 1'b1;
              if (bit_cnt == BIT_LAST) state_next = STOP;
            end else begin
              sample_inc = 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sample_cnt == SAMPLE_LAST) begin
              sample_clr = 1'b1;
              if (rx_s) begin
                load_data  = 1'b1;
                state_next = IDLE;
              end else begin
                set_ferr   = 1'b1;
                state_next = WAIT_HIGH;
              end
            end else begin
              sample_inc = 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          sample_clr = 1'b1;
          if (rx_s) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Counters, shift register and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (sample_clr)      sample_cnt <= '0;
      else if (sample_inc) sample_cnt <= sample_cnt + SW'(1);
      if (bit_clr)         bit_cnt <= '0;
      else if (bit_inc)    bit_cnt <= bit_cnt + BW'(1);
      if (!rx_en)          shift_reg <= '0;
      else if (shift_en)   shift_reg <= {rx_s, shift_reg[7:1]};
      if (load_data)       rx_data <= shift_reg;
      rx_valid  <= load_data;
      frame_err <= set_ferr;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam int BIT_CYC = 16;

  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int total;
  int bad;
  int cyc;
  int valid_cnt;
  int ferr_cnt;
  int busy_cycles;
  logic [7:0] vdata [0:31];
  int         vtime [0:31];

  uart_rx #(
    .CLOCK_RATE(1600),
    .BAUD_RATE (100),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_i     (rx_i),
    .rx_en    (rx_en),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (valid_cnt < 32) begin
          vdata[valid_cnt] <= rx_data;
          vtime[valid_cnt] <= cyc;
        end
        valid_cnt <= valid_cnt + 1;
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    wait_cycles(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_frame;
    int v0, f0, b0;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cycles;
    send_frame(8'hA5, 1'b1);
    wait_cycles(20);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL single_valid_count got=%0d exp=1", valid_cnt - v0); end
    total++; if (vdata[v0] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", vdata[v0]); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_rx_data_hold got=%h exp=a5", rx_data); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL single_no_ferr got=%0d exp=0", ferr_cnt - f0); end
    total++; if (busy_cycles - b0 !== 152) begin bad++; $display("FAIL single_busy_cycles got=%0d exp=152", busy_cycles - b0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cycles(20);
    total++; if (valid_cnt - v0 !== 2) begin bad++; $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt - v0); end
    total++; if (vdata[v0] !== 8'h00) begin bad++; $display("FAIL b2b_first_data got=%h exp=00", vdata[v0]); end
    total++; if (vdata[v0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second_data got=%h exp=ff", vdata[v0+1]); end
    total++; if (vtime[v0+1] - vtime[v0] !== 160) begin bad++; $display("FAIL b2b_spacing got=%0d exp=160", vtime[v0+1] - vtime[v0]); end
  endtask

  task automatic test_glitch;
    int v0, f0, b0;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cycles;
    rx_i = 1'b0;
    wait_cycles(4);
    rx_i = 1'b1;
    wait_cycles(40);
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL glitch_no_valid got=%0d exp=0", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_no_ferr got=%0d exp=0", ferr_cnt - f0); end
    total++; if (busy_cycles - b0 !== 8) begin bad++; $display("FAIL glitch_busy_cycles got=%0d exp=8", busy_cycles - b0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    rx_i = 1'b0;
    wait_cycles(50);
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL ferr_rx_data_held got=%h exp=ff", rx_data); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL ferr_no_decode_in_break got=%0d exp=0", valid_cnt - v0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_in_break got=%b exp=1", busy); end
    rx_i = 1'b1;
    wait_cycles(BIT_CYC);
    send_frame(8'h81, 1'b1);
    wait_cycles(20);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL ferr_next_valid_count got=%0d exp=1", valid_cnt - v0); end
    total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL ferr_next_data got=%h exp=81", rx_data); end
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_single_pulse got=%0d exp=1", ferr_cnt - f0); end
  endtask

  task automatic test_enable_abort;
    int v0, f0;
    logic [7:0] d;
    v0 = valid_cnt; f0 = ferr_cnt;
    d = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_i = d[4];
    wait_cycles(6);
    rx_i = 1'b1;
    rx_en = 1'b0;
    wait_cycles(1);
    rx_en = 1'b1;
    wait_cycles(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_abort_busy got=%b exp=0", busy); end
    wait_cycles(200);
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL en_abort_no_valid got=%0d exp=0", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL en_abort_no_ferr got=%0d exp=0", ferr_cnt - f0); end
    total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL en_abort_data_held got=%h exp=81", rx_data); end
    send_frame(8'h12, 1'b1);
    wait_cycles(20);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL en_next_valid_count got=%0d exp=1", valid_cnt - v0); end
    total++; if (rx_data !== 8'h12) begin bad++; $display("FAIL en_next_data got=%h exp=12", rx_data); end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    logic [7:0] d;
    d = 8'hE7;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_rx_data got=%h exp=00", rx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if ((rx_valid | frame_err) !== 1'b0) begin bad++; $display("FAIL rst_mid_pulses got=%b exp=0", rx_valid | frame_err); end
    rx_i = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(BIT_CYC);
    v0 = valid_cnt;
    send_frame(8'hC3, 1'b1);
    wait_cycles(20);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL rst_next_valid_count got=%0d exp=1", valid_cnt - v0); end
    total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL rst_next_data got=%h exp=c3", rx_data); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    valid_cnt = 0;
    ferr_cnt = 0;
    busy_cycles = 0;
    rst_n = 1'b0;
    rx_i = 1'b1;
    rx_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    wait_cycles(5);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_enable_abort();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, 8N1, LSB first. It is the receive-side counterpart of the baud-tick generator that paces the transmitter. It generates its own oversampled tick internally, synchronises the asynchronous serial input, and detects and validates the start bit. Each bit is sampled at its midpoint, and the block delivers one byte per frame with a one-cycle valid pulse, or flags a framing error. It sits between the board RX pin and the byte-level consumer (FIFO/command parser).

Parameters:
CLOCK_RATE, 100000000, system clock frequency in Hz.
BAUD_RATE, 115200, serial bit rate in bit/s.
OVERSAMPLE, 16, ticks per bit period; must be even and >= 4.
TICK_DIV, CLOCK_RATE/(BAUD_RATE*OVERSAMPLE), derived (local); clk cycles per tick; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
rx_i  input  1  asynchronous serial line; idles high.
rx_en  input  1  receiver enable; low = abort and hold idle.
rx_data  output  8  last correctly received byte.
rx_valid  output  1  one-cycle pulse; rx_data is updated in the same cycle.
frame_err  output  1  one-cycle pulse when the stop bit samples low.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): synchroniser flops = 1, state = IDLE, all counters = 0, shift register = 0. Outputs: rx_data = 0, rx_valid = 0, frame_err = 0, busy = 0.
- Synchroniser: 2-FF chain on rx_i; all logic uses the second flop (rx_s), so there are 2 cycles of input latency.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and emits tick for one cycle when it wraps, so tick period = TICK_DIV cycles exactly.
  - Counter is cleared in IDLE, in WAIT_HIGH and whenever rx_en = 0, so tick phase is aligned to start-bit detection.
- Sample counter (width $clog2(OVERSAMPLE)) increments on each tick; bit counter is 0..7.
- IDLE: when rx_en = 1 and rx_s = 0 → go to START; clear tick and sample counters.
- START: on the tick where the sample count reaches OVERSAMPLE/2-1 (mid start bit):
  - rx_s = 1 → treat as a glitch, return to IDLE with no output.
  - rx_s = 0 → clear sample counter, bit counter = 0, go to DATA.
- DATA: every OVERSAMPLE ticks (mid-bit), shift rx_s into bit 7 of the shift register (right shift, so LSB arrives first) and increment the bit counter. After the 8th sample → go to STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - rx_s = 1 → rx_data <= shift register, rx_valid = 1 for the next cycle, go to IDLE.
  - rx_s = 0 → frame_err = 1 for the next cycle, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- Latency: rx_valid asserts 1 cycle after the mid-stop-bit tick. IDLE is re-entered in that same cycle, so a start bit that follows immediately is accepted (back-to-back frames at full rate).
- rx_en = 0 in any state: synchronously return to IDLE next cycle and clear counters. Shift-register contents are discarded, no pulses are emitted, and rx_data is held.
- rst_n asserted mid-frame: immediate return to reset values; the partial byte is lost.
- rx_valid and frame_err are mutually exclusive and never assert in consecutive cycles for the same frame.
- Integer truncation in TICK_DIV is accepted. Bit-rate error must stay within ±2% for the chosen parameters; this is checked by an elaboration-time assertion.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, STOP, WAIT_HIGH), UART_DATA_BITS = 8, and a function computing TICK_DIV from CLOCK_RATE, BAUD_RATE and OVERSAMPLE.
- One sub-module, uart_rx_tick_gen: parameter TICK_DIV; ports clk, rst_n, clear, tick. Shares its divider style with the transmit-side baud generator.
- State machine, sampling logic and shift register stay in uart_rx.

Test Plan:
- Sim parameters for all tests: CLOCK_RATE = 1600, BAUD_RATE = 100, OVERSAMPLE = 16, so TICK_DIV = 1 and one bit = 16 cycles.
- Drive frame 0xA5 (line pattern 0,1,0,1,0,0,1,0,1,1) → exactly one rx_valid pulse with rx_data = 0xA5, frame_err never asserts, busy high for the frame then low.
- Back-to-back 0x00 then 0xFF with no idle gap → two rx_valid pulses 160 cycles apart, rx_data = 0x00 then 0xFF.
- Pull rx_i low for 4 cycles then high → busy pulses and returns to IDLE at mid-start, no rx_valid, no frame_err.
- Frame 0x3C with stop bit = 0, line held low a further 50 cycles, then 0x81 → frame_err pulse, rx_data stays at its prior value, no decode during the low hold, then rx_valid with rx_data = 0x81.
- rx_en dropped for 1 cycle during bit 4 of 0x55, then re-asserted with the line idle → no output, busy = 0; the next frame 0x12 is received correctly.
- rst_n pulsed low mid-DATA → outputs immediately at reset values; the following frame 0xC3 is received correctly.
